// File: rtl/aqua_pkg.sv
// aqua_pkg: shared state encoding, severity-to-level and actuator decode helpers
package aqua_pkg;
  typedef enum logic [1:0] {SN = 2'b00, SW = 2'b01, SC = 2'b10, SX = 2'b11} state_t;
  localparam int ACT_W = 6;
  function automatic state_t sev_lvl(input logic [1:0] s);
    return s[1] ? SC : (s[0] ? SW : SN);
  endfunction
  // Actuator vector order: {pump, aerator, valve, heater, uv, feeder}; illegal SX decodes as SC
  function automatic logic [ACT_W-1:0] act_dec(input state_t s);
    return (s == SN) ? 6'b010001 : (s == SW) ? 6'b111001 : 6'b111110;
  endfunction
endpackage

// File: rtl/aqua_multi_fsm_if.sv
// aqua_multi_fsm_if: sensor/control inputs and per-channel status/actuator outputs
// master drives sample_en, sev, feed_inhibit, alarm_clr; slave drives state, actuators, flags
interface aqua_multi_fsm_if #(parameter int N_CH = 4);
  logic              sample_en;
  logic [2*N_CH-1:0] sev;
  logic              feed_inhibit;
  logic              alarm_clr;
  logic [2*N_CH-1:0] state;
  logic [N_CH-1:0]   pump, aerator, valve, heater, uv, feeder;
  logic              any_critical;
  logic              alarm_latched;
  modport master (output sample_en, sev, feed_inhibit, alarm_clr,
                  input state, pump, aerator, valve, heater, uv, feeder, any_critical, alarm_latched);
  modport slave  (input sample_en, sev, feed_inhibit, alarm_clr,
                  output state, pump, aerator, valve, heater, uv, feeder, any_critical, alarm_latched);
endinterface

// File: rtl/aqua_chan_fsm.sv
// aqua_chan_fsm: one tank's Normal/Warning/Critical FSM with dwell de-escalation and pump min-on
// in: clk, rst_n, i_sample_en, i_sev, i_feed_inhibit; out: o_state, o_act, o_enter_sc
module aqua_chan_fsm
  import aqua_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int PUMP_MIN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sample_en,
  input  logic [1:0]       i_sev,
  input  logic             i_feed_inhibit,
  output logic [1:0]       o_state,
  output logic [ACT_W-1:0] o_act,
  output logic             o_enter_sc
);
  localparam int CW = $clog2(DWELL + 1);
  localparam int TW = (PUMP_MIN > 1) ? $clog2(PUMP_MIN + 1) : 1;
  localparam logic [TW-1:0] TLOAD = TW'((PUMP_MIN > 0) ? PUMP_MIN - 1 : 0);
  state_t           r_state, w_next, w_lvl;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [TW-1:0]    r_tmr;
  logic             r_req_q;
  logic [ACT_W-1:0] w_dec;
  assign w_lvl = sev_lvl(i_sev);
  assign w_dec = act_dec(r_state);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SN;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_req_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_req_q <= w_dec[5];
      r_tmr   <= (w_dec[5] && !r_req_q) ? TLOAD : (r_tmr != '0) ? r_tmr - TW'(1) : r_tmr;
    end
  end
  // Dwell counts consecutive lower-level strobes; any strobe at or above the state restarts it
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (r_state == SX) begin
      w_next = SC;
      w_cnt  = '0;
    end else if (i_sample_en) begin
      if (w_lvl > r_state) begin
        w_next = w_lvl;
        w_cnt  = '0;
      end else if (w_lvl == r_state) begin
        w_cnt = '0;
      end else if (r_cnt == CW'(DWELL - 1)) begin
        w_next = state_t'(r_state - 2'd1);
        w_cnt  = '0;
      end else begin
        w_cnt = r_cnt + CW'(1);
      end
    end
  end
  assign o_state    = r_state;
  assign o_enter_sc = (w_next == SC) && (r_state != SC);
  assign o_act      = {w_dec[5] | (r_tmr != '0), w_dec[4:1], w_dec[0] & ~i_feed_inhibit};
endmodule

// File: rtl/aqua_multi_fsm.sv
// aqua_multi_fsm: N_CH independent tank FSMs plus sticky alarm and critical OR-reduction
// in: clk, rst_n, bus (slave: sample_en, sev, feed_inhibit, alarm_clr)
// out via bus: state, pump, aerator, valve, heater, uv, feeder, any_critical, alarm_latched
module aqua_multi_fsm
  import aqua_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DWELL    = 4,
  parameter int PUMP_MIN = 16
) (
  input logic              clk,
  input logic              rst_n,
  aqua_multi_fsm_if.slave  bus
);
  logic [ACT_W-1:0]  w_act [N_CH];
  logic [2*N_CH-1:0] w_state;
  logic [N_CH-1:0]   w_enter, w_crit, w_pump, w_aer, w_valve, w_heat, w_uv, w_feed;
  logic              r_alarm;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    aqua_chan_fsm #(.DWELL(DWELL), .PUMP_MIN(PUMP_MIN)) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_sample_en   (bus.sample_en),
      .i_sev         (bus.sev[2*i+:2]),
      .i_feed_inhibit(bus.feed_inhibit),
      .o_state       (w_state[2*i+:2]),
      .o_act         (w_act[i]),
      .o_enter_sc    (w_enter[i])
    );
    assign {w_pump[i], w_aer[i], w_valve[i], w_heat[i], w_uv[i], w_feed[i]} = w_act[i];
    // Both SC and illegal 11 count as critical
    assign w_crit[i] = w_state[2*i+1];
  end
  // Set on a fresh SC entry beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alarm <= 1'b0;
    else        r_alarm <= (|w_enter) ? 1'b1 : bus.alarm_clr ? 1'b0 : r_alarm;
  end
  assign bus.state         = w_state;
  assign bus.pump          = w_pump;
  assign bus.aerator       = w_aer;
  assign bus.valve         = w_valve;
  assign bus.heater        = w_heat;
  assign bus.uv            = w_uv;
  assign bus.feeder        = w_feed;
  assign bus.any_critical  = |w_crit;
  assign bus.alarm_latched = r_alarm;
endmodule

// File: tb/tb_aqua_multi_fsm.sv
// tb_aqua_multi_fsm: directed self-checking bench for aqua_multi_fsm (N_CH=4, DWELL=4, PUMP_MIN=16)
module tb_aqua_multi_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  aqua_multi_fsm_if #(.N_CH(4)) bus ();
  aqua_multi_fsm #(.N_CH(4), .DWELL(4), .PUMP_MIN(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [7:0] s);
    bus.sev = s;
    bus.sample_en = 1'b1;
    step();
    bus.sample_en = 1'b0;
  endtask
  initial begin
    bus.sample_en = 1'b0;
    bus.sev = '0;
    bus.feed_inhibit = 1'b0;
    bus.alarm_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", bus.state, 8'h00);
    chk("rst_aerator", bus.aerator, 4'hF);
    chk("rst_feeder", bus.feeder, 4'hF);
    chk("rst_pump", bus.pump, 4'h0);
    chk("rst_alarm", bus.alarm_latched, 1'b0);
    bus.feed_inhibit = 1'b1;
    #1 chk("rst_inhibit", bus.feeder, 4'h0);
    bus.feed_inhibit = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    chk("idle_state", bus.state, 8'h00);
    strobe(8'b00_00_00_10);
    chk("esc_state", bus.state, 8'h02);
    chk("esc_heater", bus.heater, 4'b0001);
    chk("esc_uv", bus.uv, 4'b0001);
    chk("esc_feeder", bus.feeder, 4'b1110);
    chk("esc_pump", bus.pump, 4'b0001);
    chk("esc_crit", bus.any_critical, 1'b1);
    chk("esc_alarm", bus.alarm_latched, 1'b1);
    bus.feed_inhibit = 1'b1;
    #1 chk("inhibit_feeder", bus.feeder, 4'h0);
    bus.feed_inhibit = 1'b0;
    strobe(8'h00);
    step();
    strobe(8'h00);
    step();
    step();
    strobe(8'h00);
    chk("dwell3_sc", bus.state, 8'h02);
    strobe(8'h00);
    chk("dwell4_sw", bus.state, 8'h01);
    chk("sw_heater", bus.heater, 4'h0);
    chk("sw_crit", bus.any_critical, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      strobe(8'h00);
      chk("dwell_sw_hold", bus.state, 8'h01);
    end
    strobe(8'h00);
    chk("dwell_sn", bus.state, 8'h00);
    strobe(8'h02);
    strobe(8'h00);
    strobe(8'h00);
    strobe(8'h02);
    for (int k = 1; k <= 3; k++) begin
      strobe(8'h00);
      chk("intr_sc_hold", bus.state, 8'h02);
    end
    strobe(8'h00);
    chk("intr_sw", bus.state, 8'h01);
    for (int k = 1; k <= 4; k++) strobe(8'h00);
    chk("intr_sn", bus.state, 8'h00);
    bus.alarm_clr = 1'b1;
    step();
    bus.alarm_clr = 1'b0;
    chk("alarm_clr", bus.alarm_latched, 1'b0);
    for (int k = 0; k < 20; k++) step();
    chk("pump_idle", bus.pump, 4'h0);
    strobe(8'b00_00_01_00);
    chk("p_sw", bus.state, 8'h04);
    chk("p_rise", bus.pump, 4'b0010);
    chk("p_noalarm", bus.alarm_latched, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      bus.sev = 8'h00;
      bus.sample_en = (k % 2 == 1) && (k <= 7);
      step();
      chk("p_state", bus.state, (k >= 7) ? 8'h00 : 8'h04);
      chk("p_pump", bus.pump[1], k < 16);
    end
    bus.sample_en = 1'b0;
    strobe(8'b10_00_00_00);
    chk("a_set", bus.alarm_latched, 1'b1);
    bus.alarm_clr = 1'b1;
    strobe(8'b10_10_00_00);
    chk("a_state", bus.state, 8'hA0);
    chk("a_setwins", bus.alarm_latched, 1'b1);
    step();
    bus.alarm_clr = 1'b0;
    chk("a_cleared", bus.alarm_latched, 1'b0);
    chk("a_still_sc", bus.state, 8'hA0);
    chk("a_crit", bus.any_critical, 1'b1);
    strobe(8'b00_10_00_00);
    strobe(8'b00_10_00_00);
    chk("mr_pre_state", bus.state, 8'hA0);
    chk("mr_pre_pump", bus.pump, 4'b1100);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_state", bus.state, 8'h00);
    chk("mr_pump", bus.pump, 4'h0);
    chk("mr_aerator", bus.aerator, 4'hF);
    chk("mr_alarm", bus.alarm_latched, 1'b0);
    chk("mr_crit", bus.any_critical, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    chk("mr_post_pump", bus.pump, 4'h0);
    chk("mr_post_state", bus.state, 8'h00);
    strobe(8'b10_00_00_00);
    for (int k = 1; k <= 3; k++) strobe(8'h00);
    chk("mr_dwell_cleared", bus.state, 8'h80);
    strobe(8'h00);
    chk("mr_dwell_sw", bus.state, 8'h40);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/aqua_multi_fsm.md
Name: aqua_multi_fsm

Overview:
- Multi-tank successor to the single-tank aquaculture Moore FSM. Runs N_CH independent Normal/Warning/Critical channel FSMs from 2-bit sensor severity codes.
- Adds sampling strobe, dwell-filtered de-escalation, pump minimum-on time, global feed inhibit and a sticky alarm.
- Sits between the sensor-threshold front end and the actuator drivers.

Parameters:
- N_CH, 4, number of tanks/channels (>=1)
- DWELL, 4, consecutive lower-severity samples required per one-level de-escalation (>=1)
- PUMP_MIN, 16, minimum pump on-time in clk cycles after pump turn-on (0 = disabled)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- sample_en  in  1  sensor sample strobe; sev is consumed only on cycles where this is 1
- sev  in  2*N_CH  per-channel severity, ch i at [2i+1:2i]: 00 normal, 01 warning, 10/11 critical
- feed_inhibit  in  1  global feeder disable
- alarm_clr  in  1  clears alarm_latched
- state  out  2*N_CH  per-channel state: 00 SN, 01 SW, 10 SC
- pump, aerator, valve, heater, uv, feeder  out  N_CH each  per-channel actuators
- any_critical  out  1  OR over channels of (state==SC)
- alarm_latched  out  1  sticky: some channel entered SC

Behaviour:
- Reset, asynchronous:
  - all states SN, dwell counters 0, pump timers 0, alarm_latched 0.
  - Outputs during reset: aerator all 1; feeder all 1 when feed_inhibit=0, else 0; all other outputs 0.
- Severity level L: 00→SN, 01→SW, 1x→SC. Per-channel state changes only on posedge where sample_en=1. Latency from sev to state is one clock.
- Escalation: if L > state, state←L immediately (SN→SC is allowed directly) and dwell counter←0.
- Hold: if L == state, dwell counter←0.
- De-escalation:
  - If L < state, dwell counter increments.
  - On the DWELL-th consecutive such sample, state steps down one level only (SC→SW, SW→SN) and the counter←0.
  - SC with continuous 00 samples therefore needs DWELL samples to reach SW, then DWELL more to reach SN.
- Interrupted dwell: any sample with L >= state resets the counter. Cycles with sample_en=0 neither advance nor reset it.
- Illegal state 11: outputs decode as SC; next clock forces SC.
- Output decode (Moore, combinational from state):
  - SN: aerator, feeder.
  - SW: pump, aerator, valve, feeder.
  - SC: pump, aerator, valve, heater, uv; feeder=0.
  - feed_inhibit=1 forces feeder=0 in all states, same cycle.
- Pump minimum-on:
  - When the decoded pump request rises 0→1, the timer loads PUMP_MIN-1.
  - pump = request OR (timer != 0). The timer decrements every clk while nonzero.
  - A new rise while the timer runs reloads it.
  - PUMP_MIN=0 makes pump equal to the request.
- Alarm:
  - alarm_latched sets on the clock edge where any channel transitions into SC.
  - alarm_clr=1 clears it. Set wins over a simultaneous clear.
  - Held while a channel remains in SC? No: it re-sets only on a new SC entry.
- any_critical is combinational from state.
- Channels are fully independent; simultaneous events on different channels are all applied in the same cycle.

Decomposition:
- Package aqua_pkg holds:
  - state constants SN/SW/SC;
  - 2-bit severity-to-level function;
  - actuator decode function (state → 6-bit actuator vector).
- Sub-module aqua_chan_fsm contains:
  - one channel's state register;
  - dwell counter, width $clog2(DWELL+1);
  - pump timer, width $clog2(PUMP_MIN+1).
- Top generates N_CH instances plus the alarm latch and OR-reductions.

Test Plan:
- Reset: hold rst_n=0 → state=0, aerator=4'hF, feeder=4'hF, pump=0, alarm_latched=0. Assert feed_inhibit=1 → feeder=0 the same cycle.
- Escalation: ch0 sev=10, sample_en pulse → next cycle state[1:0]=10, heater[0]=uv[0]=1, feeder[0]=0, any_critical=1, alarm_latched=1; other channels stay SN.
- Dwell: ch0 in SC, DWELL=4:
  - sev=00 on 3 strobes → still SC; 4th strobe → SW.
  - 4 more strobes → SN.
  - Insert sev=10 at strobe 3 → counter resets, stays SC.
  - Strobe gaps (sample_en=0) must not change the count.
- Pump min-on: PUMP_MIN=16, ch1 SW entered then SN after DWELL samples at 2 clocks/strobe (8 cycles) → pump[1] stays 1 until 16 cycles after rise, then 0.
- Alarm clear: alarm_latched=1, alarm_clr=1 while ch2 enters SC the same cycle → stays 1. Next alarm_clr with no entry → 0 even though ch2 still SC.
- Mid-operation reset: ch3 in SC with dwell count 2, pump timer running, rst_n low for 1 cycle → all counters 0, state SN, pump[3]=0 immediately (asynchronous).
